// File: rtl/musa_program_loader.sv
`timescale 1ns/1ps
// Framed byte-stream loader: assembles big-endian 32-bit words, writes them to
// instruction memory at consecutive addresses and holds the core while loading.
module musa_program_loader #(
  parameter int                    ADDR_WIDTH = 18,
  parameter logic [7:0]            SYNC_BYTE  = 8'hA5,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic                  imem_wren,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_HI = 3'd1;
  localparam logic [2:0] S_CNT_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;

  logic [2:0]            state;
  logic [7:0]            cnt_hi;
  logic [15:0]           cnt;
  logic [1:0]            byte_idx;
  logic [7:0]            acc;
  logic [31:0]           word;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  hold;
  logic                  done;
  logic                  err;
  logic                  xfer;
  logic [15:0]           cnt_rx;

  // Ready is a function of state only (and held low while in reset).
  assign in_ready  = !rst && (state != S_WRITE);
  assign xfer      = in_valid && in_ready;
  assign cnt_rx    = {cnt_hi, in_data};

  assign imem_wren = (state == S_WRITE);
  assign imem_addr = addr;
  assign imem_data = word;
  assign core_hold = hold;
  assign load_done = done;
  assign load_err  = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt_hi   <= 8'd0;
      cnt      <= 16'd0;
      byte_idx <= 2'd0;
      acc      <= 8'd0;
      word     <= 32'd0;
      addr     <= BASE_ADDR;
      hold     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && (in_data == SYNC_BYTE)) begin
            state    <= S_CNT_HI;
            hold     <= 1'b1;
            err      <= 1'b0;
            acc      <= 8'd0;
            addr     <= BASE_ADDR;
            byte_idx <= 2'd0;
          end
        end
        S_CNT_HI: begin
          if (xfer) begin
            cnt_hi <= in_data;
            state  <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (xfer) begin
            cnt   <= cnt_rx;
            state <= (cnt_rx == 16'd0) ? S_CHECK : S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            word     <= {word[23:0], in_data};
            acc      <= acc ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Address advances after the write cycle; wraps naturally at 2^ADDR_WIDTH.
          cnt   <= cnt - 16'd1;
          addr  <= addr + 1'b1;
          state <= (cnt == 16'd1) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (xfer) begin
            hold  <= 1'b0;
            state <= S_IDLE;
            if (in_data == acc) done <= 1'b1;
            else                err  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_musa_program_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for musa_program_loader: one instance at BASE_ADDR 0 and one
// at 18'h3FFFF (address wrap) share the same byte stream.
module tb_musa_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready0, wren0, hold0, done0, err0;
  logic [17:0] addr0;
  logic [31:0] data0;
  logic        in_ready1, wren1, hold1, done1, err1;
  logic [17:0] addr1;
  logic [31:0] data1;

  localparam logic [17:0] BASE0 = 18'h00000;
  localparam logic [17:0] BASE1 = 18'h3FFFF;

  always #5 clk = ~clk;

  musa_program_loader u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .imem_addr(addr0), .imem_data(data0),
    .imem_wren(wren0), .core_hold(hold0), .load_done(done0), .load_err(err0)
  );

  musa_program_loader #(.BASE_ADDR(BASE1)) u_wrap (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .imem_addr(addr1), .imem_data(data1),
    .imem_wren(wren1), .core_hold(hold1), .load_done(done1), .load_err(err1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues: {addr, data} per instance, and frame outcome (1 = done, 2 = err).
  logic [49:0] q0[$];
  logic [49:0] q1[$];
  int          evq[$];
  logic [49:0] e0, e1;
  int          ev;
  logic        prev_wren0 = 1'b0;
  logic        prev_err0  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wren0) begin
        check("wr0_pending", 64'(q0.size() != 0), 64'(1));
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          check("wr0_addr", 64'(addr0), 64'(e0[49:32]));
          check("wr0_data", 64'(data0), 64'(e0[31:0]));
        end
        check("wr0_ready_low", 64'(in_ready0), 64'(0));
        check("wr0_one_cycle", 64'(prev_wren0), 64'(0));
      end
      if (wren1) begin
        check("wr1_pending", 64'(q1.size() != 0), 64'(1));
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          check("wr1_addr", 64'(addr1), 64'(e1[49:32]));
          check("wr1_data", 64'(data1), 64'(e1[31:0]));
        end
      end
      if (done0 || (err0 && !prev_err0)) begin
        check("ev_pending", 64'(evq.size() != 0), 64'(1));
        if (evq.size() != 0) begin
          ev = evq.pop_front();
          check("ev_kind", 64'(done0 ? 1 : 2), 64'(ev));
          check("ev_hold_low", 64'(hold0), 64'(0));
        end
      end
    end
    prev_wren0 <= wren0;
    prev_err0  <= err0;
  end

  bit gaps = 1'b0;

  // Offer one byte; returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int t;
    while (gaps && ($urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("ready_timeout", 64'(in_ready0), 64'(1));
    @(posedge clk); #1;
  endtask

  logic [31:0] fw[0:3];

  task automatic send_frame(input int n, input bit bad);
    logic [7:0] chk;
    chk = 8'h00;
    for (int i = 0; i < n; i++) begin
      q0.push_back({BASE0 + 18'(i), fw[i]});
      q1.push_back({BASE1 + 18'(i), fw[i]});
      chk = chk ^ fw[i][31:24] ^ fw[i][23:16] ^ fw[i][15:8] ^ fw[i][7:0];
    end
    if (bad) chk = chk ^ 8'h01;
    evq.push_back(bad ? 2 : 1);
    send_byte(8'hA5);
    check("sync_hold_set", 64'(hold0), 64'(1));
    check("sync_err_clr", 64'(err0), 64'(0));
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    for (int i = 0; i < n; i++)
      for (int j = 3; j >= 0; j--) send_byte(fw[i][j*8 +: 8]);
    send_byte(chk);
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  64'(in_ready0), 64'(0));
    check("rst_wren",   64'(wren0),     64'(0));
    check("rst_addr",   64'(addr0),     64'(BASE0));
    check("rst_data",   64'(data0),     64'(0));
    check("rst_hold",   64'(hold0),     64'(0));
    check("rst_done",   64'(done0),     64'(0));
    check("rst_err",    64'(err0),      64'(0));
    check("rst_addr_w", 64'(addr1),     64'(BASE1));
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(in_ready0), 64'(1));

    // Preamble garbage then an empty frame.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    in_valid = 1'b0;
    check("preamble_no_hold", 64'(hold0), 64'(0));
    send_frame(0, 1'b0);
    check("empty_hold", 64'(hold0), 64'(0));

    // Two-word frame, good checksum (0x2A).
    fw[0] = 32'h12345678; fw[1] = 32'hDEADBEEF;
    send_frame(2, 1'b0);
    check("two_done", 64'(done0), 64'(1));
    check("two_err",  64'(err0),  64'(0));
    @(posedge clk); #1;
    check("two_done_pulse", 64'(done0), 64'(0));
    check("two_hold", 64'(hold0), 64'(0));

    // Same frame with checksum 0x2B: words still written, sticky error.
    send_frame(2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("bad_err_sticky", 64'(err0),  64'(1));
    check("bad_hold",       64'(hold0), 64'(0));
    check("bad_no_done",    64'(done0), 64'(0));

    // Source gaps; the SYNC byte of this frame also clears the error.
    gaps = 1'b1;
    send_frame(2, 1'b0);
    check("gap_err", 64'(err0), 64'(0));

    // Random three-word frame with gaps.
    for (int i = 0; i < 3; i++) fw[i] = $urandom;
    send_frame(3, 1'b0);
    gaps = 1'b0;

    // Reset after two data bytes of the first word: nothing is written.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_hold", 64'(hold0), 64'(0));
    check("midrst_wren", 64'(wren0), 64'(0));
    check("midrst_addr", 64'(addr0), 64'(BASE0));
    repeat (3) @(posedge clk);
    #1;
    fw[0] = 32'h12345678; fw[1] = 32'hDEADBEEF;
    send_frame(2, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    check("q0_drained",  64'(q0.size()),  64'(0));
    check("q1_drained",  64'(q1.size()),  64'(0));
    check("evq_drained", 64'(evq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
